// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retire queue with ALU wakeup broadcast and commit-time mispredict flush.
// Latency: allocate visible next edge; writeback -> bcast at +1 edge; ready -> commit at +1 edge.
// Backpressure: decoder stalls on rob_full (allocations while full are dropped); rdy low freezes all state.
//
// Optional feature: define ROB_BYPASS_EN to let a writeback aimed at the non-ready head
// commit on the same edge (writeback-to-commit and mispredict detection one edge earlier).
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   id_*      : allocation request from decode; rob_new_id / rob_full back to decode
//   alu_*     : ALU writeback (value, actual branch direction and target)
//   bcast_*   : registered wakeup broadcast (id, value) to reservation station / regfile
//   rf_commit_*: registered in-order regfile write at retire, with the retiring id
//   flush, flush_pc : registered mispredict flush pulse and redirect PC
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ID_W     = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_inst_pc,
    input  logic              id_has_rd,
    input  logic [4:0]        id_rd,
    input  logic              id_is_branch,
    input  logic              id_pred_taken,
    output logic [ID_W-1:0]   rob_new_id,
    output logic              rob_full,
    input  logic              alu_valid,
    input  logic [ID_W-1:0]   alu_rob_id,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              alu_taken,
    input  logic [DATA_W-1:0] alu_target,
    output logic              bcast_valid,
    output logic [ID_W-1:0]   bcast_rob_id,
    output logic [DATA_W-1:0] bcast_value,
    output logic              rf_commit_valid,
    output logic [4:0]        rf_commit_rd,
    output logic [DATA_W-1:0] rf_commit_value,
    output logic [ID_W-1:0]   rf_commit_rob_id,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc
);

    localparam logic [ID_W:0]   FULL_CNT = (ID_W+1)'(ROB_SIZE);
    localparam logic [ID_W:0]   CNT_ONE  = (ID_W+1)'(1);
    localparam logic [ID_W-1:0] PTR_ONE  = ID_W'(1);

    // Pointers and occupancy
    logic [ID_W-1:0]     head;
    logic [ID_W-1:0]     tail;
    logic [ID_W:0]       count;
    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;

    // Per-entry payload (validity is carried by busy/ready, so no reset needed)
    logic [DATA_W-1:0] pc_q         [ROB_SIZE];
    logic              has_rd_q     [ROB_SIZE];
    logic [4:0]        rd_q         [ROB_SIZE];
    logic              is_branch_q  [ROB_SIZE];
    logic              pred_taken_q [ROB_SIZE];
    logic [DATA_W-1:0] value_q      [ROB_SIZE];
    logic              taken_q      [ROB_SIZE];
    logic [DATA_W-1:0] target_q     [ROB_SIZE];

    logic              alloc_fire;
    logic              wb_fire;
    logic              commit_fire;
    logic              commit_taken;
    logic [DATA_W-1:0] commit_value;
    logic [DATA_W-1:0] commit_target;
    logic              mispredict;
    logic              rf_fire;
    logic [DATA_W-1:0] redirect_pc;

    assign rob_new_id = tail;
    assign rob_full   = (count == FULL_CNT);

    // The cycle in which flush is high belongs to the squashed path: nothing enters.
    assign alloc_fire = id_valid && !rob_full && !flush;
    assign wb_fire    = alu_valid && !flush && busy[alu_rob_id];

    always_comb begin
        commit_fire   = busy[head] && ready[head];
        commit_value  = value_q[head];
        commit_taken  = taken_q[head];
        commit_target = target_q[head];
`ifdef ROB_BYPASS_EN
        // Head result arriving this cycle retires straight from the ALU bus.
        if (wb_fire && (alu_rob_id == head) && !ready[head]) begin
            commit_fire   = 1'b1;
            commit_value  = alu_value;
            commit_taken  = alu_taken;
            commit_target = alu_target;
        end
`endif
    end

    assign mispredict  = commit_fire && is_branch_q[head] && (commit_taken != pred_taken_q[head]);
    assign redirect_pc = commit_taken ? commit_target : (pc_q[head] + DATA_W'(4));
    assign rf_fire     = commit_fire && has_rd_q[head] && (rd_q[head] != 5'd0) && !is_branch_q[head];

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            bcast_valid      <= 1'b0;
            bcast_rob_id     <= '0;
            bcast_value      <= '0;
            rf_commit_valid  <= 1'b0;
            rf_commit_rd     <= '0;
            rf_commit_value  <= '0;
            rf_commit_rob_id <= '0;
            flush            <= 1'b0;
            flush_pc         <= '0;
        end else if (!rdy) begin
            bcast_valid     <= 1'b0;
            rf_commit_valid <= 1'b0;
            flush           <= 1'b0;
        end else begin
            bcast_valid <= wb_fire;
            if (wb_fire) begin
                bcast_rob_id <= alu_rob_id;
                bcast_value  <= alu_value;
            end

            rf_commit_valid <= rf_fire;
            if (rf_fire) begin
                rf_commit_rd     <= rd_q[head];
                rf_commit_value  <= commit_value;
                rf_commit_rob_id <= head;
            end

            flush <= mispredict;
            if (mispredict) begin
                flush_pc <= redirect_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                busy     <= '0;
                ready    <= '0;
            end else begin
                if (alloc_fire) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + PTR_ONE;
                end
                if (wb_fire) begin
                    ready[alu_rob_id] <= 1'b1;
                end
                // Retire last so a bypassed writeback to the head still leaves it free.
                if (commit_fire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + PTR_ONE;
                end
                if (alloc_fire && !commit_fire) begin
                    count <= count + CNT_ONE;
                end else if (!alloc_fire && commit_fire) begin
                    count <= count - CNT_ONE;
                end
            end
        end
    end

    // Entry payload writes
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (alloc_fire) begin
                pc_q[tail]         <= id_inst_pc;
                has_rd_q[tail]     <= id_has_rd;
                rd_q[tail]         <= id_rd;
                is_branch_q[tail]  <= id_is_branch;
                pred_taken_q[tail] <= id_pred_taken;
            end
            if (wb_fire) begin
                value_q[alu_rob_id]  <= alu_value;
                taken_q[alu_rob_id]  <= alu_taken;
                target_q[alu_rob_id] <= alu_target;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, all checked
// against a program-order queue model of the buffer.
module tb_reorder_buffer;
    localparam int ROB_SIZE = 16;
    localparam int ID_W     = 4;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst, rdy;
    logic              id_valid, id_has_rd, id_is_branch, id_pred_taken;
    logic [DATA_W-1:0] id_inst_pc;
    logic [4:0]        id_rd;
    logic [ID_W-1:0]   rob_new_id;
    logic              rob_full;
    logic              alu_valid, alu_taken;
    logic [ID_W-1:0]   alu_rob_id;
    logic [DATA_W-1:0] alu_value, alu_target;
    logic              bcast_valid;
    logic [ID_W-1:0]   bcast_rob_id;
    logic [DATA_W-1:0] bcast_value;
    logic              rf_commit_valid;
    logic [4:0]        rf_commit_rd;
    logic [DATA_W-1:0] rf_commit_value;
    logic [ID_W-1:0]   rf_commit_rob_id;
    logic              flush;
    logic [DATA_W-1:0] flush_pc;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .id_valid(id_valid), .id_inst_pc(id_inst_pc), .id_has_rd(id_has_rd), .id_rd(id_rd),
        .id_is_branch(id_is_branch), .id_pred_taken(id_pred_taken),
        .rob_new_id(rob_new_id), .rob_full(rob_full),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .alu_taken(alu_taken), .alu_target(alu_target),
        .bcast_valid(bcast_valid), .bcast_rob_id(bcast_rob_id), .bcast_value(bcast_value),
        .rf_commit_valid(rf_commit_valid), .rf_commit_rd(rf_commit_rd),
        .rf_commit_value(rf_commit_value), .rf_commit_rob_id(rf_commit_rob_id),
        .flush(flush), .flush_pc(flush_pc)
    );

    // Reference model: live instructions in program order
    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        has_rd;
        logic [4:0]  rd;
        logic        is_branch;
        logic        pred;
        logic        done;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        q[$];
    int          next_id = 0;
    logic        e_bv, e_rv, e_fl;
    logic [3:0]  e_bid, e_rid;
    logic [4:0]  e_rrd;
    logic [31:0] e_bval, e_rval, e_fpc;

    int tests_run    = 0;
    int tests_failed = 0;

    // Output logs for the directed scenarios
    int          bc_ids[$];
    int          bc_vals[$];
    int          rf_rds[$];
    int          rf_vals[$];
    logic [31:0] fl_pcs[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int   wb_idx;
        logic full, alloc, wb, commit;
        ent_t c;
        ent_t n;
        if (rst) begin
            q.delete();
            next_id = 0;
            e_bv = 0; e_bid = 0; e_bval = 0;
            e_rv = 0; e_rrd = 0; e_rval = 0; e_rid = 0;
            e_fl = 0; e_fpc = 0;
            return;
        end
        if (!rdy) begin
            e_bv = 0; e_rv = 0; e_fl = 0;
            return;
        end
        full  = (q.size() == ROB_SIZE);
        alloc = id_valid && !full && !e_fl;
        wb_idx = -1;
        if (alu_valid && !e_fl) begin
            foreach (q[i]) if (q[i].id == int'(alu_rob_id)) wb_idx = i;
        end
        wb     = (wb_idx >= 0);
        c      = '{default: 0};
        commit = 1'b0;
        if (q.size() > 0) begin
            c      = q[0];
            commit = q[0].done;
        end
`ifdef ROB_BYPASS_EN
        if (wb && wb_idx == 0 && !q[0].done) begin
            commit = 1'b1; c.value = alu_value; c.taken = alu_taken; c.target = alu_target;
        end
`endif
        e_bv = wb;
        if (wb) begin e_bid = alu_rob_id; e_bval = alu_value; end
        e_rv = commit && c.has_rd && (c.rd != 0) && !c.is_branch;
        if (e_rv) begin e_rrd = c.rd; e_rval = c.value; e_rid = 4'(c.id); end
        e_fl = commit && c.is_branch && (c.taken != c.pred);
        if (e_fl) begin
            e_fpc = c.taken ? c.target : c.pc + 32'd4;
            q.delete();
            next_id = 0;
            return;
        end
        if (wb) begin
            q[wb_idx].done   = 1'b1;
            q[wb_idx].value  = alu_value;
            q[wb_idx].taken  = alu_taken;
            q[wb_idx].target = alu_target;
        end
        if (commit) void'(q.pop_front());
        if (alloc) begin
            n = '{id: next_id, pc: id_inst_pc, has_rd: id_has_rd, rd: id_rd, is_branch: id_is_branch,
                  pred: id_pred_taken, done: 1'b0, value: 0, taken: 1'b0, target: 0};
            q.push_back(n);
            next_id = (next_id + 1) % ROB_SIZE;
        end
    endtask

    // One clock: check combinational outputs, step model, compare registered outputs.
    task automatic cycle();
        if (!rst) begin
            check_eq("rob_new_id", rob_new_id, next_id);
            check_eq("rob_full", rob_full, q.size() == ROB_SIZE);
        end
        model_step();
        @(posedge clk);
        #1;
        check_eq("bcast_valid", bcast_valid, e_bv);
        if (e_bv) begin
            check_eq("bcast_rob_id", bcast_rob_id, e_bid);
            check_eq("bcast_value", bcast_value, e_bval);
        end
        check_eq("rf_commit_valid", rf_commit_valid, e_rv);
        if (e_rv) begin
            check_eq("rf_commit_rd", rf_commit_rd, e_rrd);
            check_eq("rf_commit_value", rf_commit_value, e_rval);
            check_eq("rf_commit_rob_id", rf_commit_rob_id, e_rid);
        end
        check_eq("flush", flush, e_fl);
        if (e_fl) check_eq("flush_pc", flush_pc, e_fpc);
        if (bcast_valid) begin bc_ids.push_back(int'(bcast_rob_id)); bc_vals.push_back(int'(bcast_value)); end
        if (rf_commit_valid) begin rf_rds.push_back(int'(rf_commit_rd)); rf_vals.push_back(int'(rf_commit_value)); end
        if (flush) fl_pcs.push_back(flush_pc);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic idle();
        id_valid = 0; alu_valid = 0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic has_rd, input logic [4:0] rd,
                             input logic br, input logic pred);
        id_valid = 1; id_inst_pc = pc; id_has_rd = has_rd; id_rd = rd;
        id_is_branch = br; id_pred_taken = pred;
    endtask

    task automatic set_wb(input int id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        alu_valid = 1; alu_rob_id = 4'(id); alu_value = v; alu_taken = tk; alu_target = tg;
    endtask

    task automatic clear_logs();
        bc_ids.delete(); bc_vals.delete(); rf_rds.delete(); rf_vals.delete(); fl_pcs.delete();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        run(2);
        rst = 0;
        clear_logs();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bv"},   bcast_valid, 0);
        check_eq({tag, "_bid"},  bcast_rob_id, 0);
        check_eq({tag, "_bval"}, bcast_value, 0);
        check_eq({tag, "_rv"},   rf_commit_valid, 0);
        check_eq({tag, "_rrd"},  rf_commit_rd, 0);
        check_eq({tag, "_rval"}, rf_commit_value, 0);
        check_eq({tag, "_rid"},  rf_commit_rob_id, 0);
        check_eq({tag, "_fl"},   flush, 0);
        check_eq({tag, "_fpc"},  flush_pc, 0);
        check_eq({tag, "_newid"}, rob_new_id, 0);
        check_eq({tag, "_full"},  rob_full, 0);
    endtask

    task automatic check_three(input string tag, input int bid[3], input int bval[3],
                               input int rd[3], input int rval[3]);
        check_eq({tag, "_bcast_cnt"}, bc_ids.size(), 3);
        check_eq({tag, "_commit_cnt"}, rf_rds.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < bc_ids.size()) begin
                check_eq({tag, "_bcast_id"}, bc_ids[i], bid[i]);
                check_eq({tag, "_bcast_val"}, bc_vals[i], bval[i]);
            end
            if (i < rf_rds.size()) begin
                check_eq({tag, "_commit_rd"}, rf_rds[i], rd[i]);
                check_eq({tag, "_commit_val"}, rf_vals[i], rval[i]);
            end
        end
    endtask

    initial begin
        rst = 1; rdy = 1;
        id_valid = 0; id_inst_pc = 0; id_has_rd = 0; id_rd = 0; id_is_branch = 0; id_pred_taken = 0;
        alu_valid = 0; alu_rob_id = 0; alu_value = 0; alu_taken = 0; alu_target = 0;

        do_reset();
        check_all_zero("reset");

        // In-order allocate, in-order writeback
        for (int i = 0; i < 3; i++) begin set_alloc(32'(i * 4), 1, 5'(i + 1), 0, 0); cycle(); end
        idle();
        for (int i = 0; i < 3; i++) begin set_wb(i, 32'hA + 32'(i), 0, 0); cycle(); end
        idle(); run(4);
        check_three("inorder", '{0, 1, 2}, '{10, 11, 12}, '{1, 2, 3}, '{10, 11, 12});
        check_eq("inorder_empty_full", rob_full, 0);
        check_eq("inorder_tail", rob_new_id, 3);

        // Out-of-order writeback, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin set_alloc(32'h40 + 32'(i * 4), 1, 5'(i + 4), 0, 0); cycle(); end
        set_wb(2, 32'h22, 0, 0); cycle();
        set_wb(1, 32'h11, 0, 0); cycle();
        check_eq("ooo_no_early_commit", rf_rds.size(), 0);
        set_wb(0, 32'h10, 0, 0); cycle();
        idle(); run(4);
        check_three("ooo", '{2, 1, 0}, '{34, 17, 16}, '{4, 5, 6}, '{16, 17, 34});

        // Fill to capacity, drop the 17th, retire one, reuse id 0
        do_reset();
        for (int i = 0; i < 16; i++) begin set_alloc(32'(i * 4), 1, 5'(i + 1), 0, 0); cycle(); end
        idle();
        check_eq("full_after_16", rob_full, 1);
        set_alloc(32'h80, 1, 5'd20, 0, 0); cycle(); idle();
        check_eq("drop_tail", rob_new_id, 0);
        check_eq("drop_still_full", rob_full, 1);
        set_wb(0, 32'h55, 0, 0); cycle(); idle(); cycle();
        check_eq("full_released", rob_full, 0);
        check_eq("reuse_id", rob_new_id, 0);
        set_alloc(32'h84, 1, 5'd21, 0, 0); cycle(); idle();
        check_eq("after_reuse_tail", rob_new_id, 1);
        check_eq("after_reuse_full", rob_full, 1);

        // Mispredict: not-taken prediction, actually taken
        do_reset();
        set_alloc(32'h100, 0, 0, 1, 0); cycle();
        set_alloc(32'h104, 1, 5'd7, 0, 0); cycle();
        set_alloc(32'h108, 1, 5'd8, 0, 0); cycle();
        set_wb(1, 32'h71, 0, 0); cycle();
        set_wb(2, 32'h81, 0, 0); cycle();
        set_wb(0, 32'h0, 1, 32'h200); cycle();
        idle(); run(4);
        check_eq("br_flush_cnt", fl_pcs.size(), 1);
        if (fl_pcs.size() > 0) check_eq("br_flush_pc", fl_pcs[0], 32'h200);
        check_eq("br_younger_squashed", rf_rds.size(), 0);
        check_eq("br_new_id", rob_new_id, 0);

        // Mispredict: taken prediction, not taken, PC wraps
        do_reset();
        set_alloc(32'hFFFF_FFFC, 0, 0, 1, 1); cycle();
        set_wb(0, 32'h0, 0, 32'h1234); cycle();
        idle(); run(3);
        check_eq("wrap_flush_cnt", fl_pcs.size(), 1);
        if (fl_pcs.size() > 0) check_eq("wrap_flush_pc", fl_pcs[0], 32'h0);

        // rdy low freezes everything; then reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) begin set_alloc(32'(i * 4), 1, 5'(i + 1), 0, 0); cycle(); end
        idle();
        rdy = 0;
        set_wb(0, 32'h99, 0, 0); run(3);
        rdy = 1; idle(); run(3);
        check_eq("rdy_no_bcast", bc_ids.size(), 0);
        check_eq("rdy_no_commit", rf_rds.size(), 0);
        check_eq("rdy_tail_held", rob_new_id, 5);
        set_wb(1, 32'h77, 0, 0);
        rst = 1; cycle(); rst = 0; idle();
        check_all_zero("mid_reset");

        // Randomized traffic
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(499) == 0);
            rdy = ($urandom_range(9) != 0);
            id_valid = $urandom_range(1);
            id_inst_pc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom;
            id_has_rd = $urandom_range(3) != 0;
            id_rd = 5'($urandom_range(31));
            id_is_branch = ($urandom_range(3) == 0);
            id_pred_taken = $urandom_range(1);
            alu_valid = ($urandom_range(9) < 6);
            if (q.size() > 0 && $urandom_range(4) != 0)
                alu_rob_id = 4'(q[$urandom_range(q.size() - 1)].id);
            else
                alu_rob_id = 4'($urandom_range(15));
            alu_value = $urandom;
            alu_taken = $urandom_range(1);
            alu_target = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer that allocates ROB ids to decoded instructions in program order.
- Accepts ALU results and rebroadcasts them (id, value) to the reservation station and regfile for operand wakeup.
- Retires one instruction per cycle in order, writing rd to the regfile.
- Produces the pipeline flush and the redirect PC on a branch mispredict detected at commit.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- ID_W, 4, ROB id width, log2(ROB_SIZE).
- DATA_W, 32, data/PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low freezes all state
- id_valid  in  1  allocate request from decoder
- id_inst_pc  in  32  PC of the instruction being allocated
- id_has_rd  in  1  instruction writes rd
- id_rd  in  5  destination register
- id_is_branch  in  1  conditional branch
- id_pred_taken  in  1  predicted direction
- rob_new_id  out  ID_W  id the next allocation receives (= tail), combinational
- rob_full  out  1  count == ROB_SIZE, combinational
- alu_valid  in  1  ALU writeback
- alu_rob_id  in  ID_W  entry being written back
- alu_value  in  32  result (rd value)
- alu_taken  in  1  actual branch direction
- alu_target  in  32  actual taken target
- bcast_valid  out  1  broadcast pulse
- bcast_rob_id  out  ID_W  broadcast id
- bcast_value  out  32  broadcast value
- rf_commit_valid  out  1  regfile write pulse
- rf_commit_rd  out  5  register written at commit
- rf_commit_value  out  32  value written at commit
- rf_commit_rob_id  out  ID_W  id retired, so the regfile clears its tag on match
- flush  out  1  mispredict flush pulse
- flush_pc  out  32  redirect PC

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset, all outputs are 0: bcast_*, rf_commit_*, flush and flush_pc. head = tail = count = 0 and every busy/ready bit is cleared. Reset wins over every other input.
- When rdy is low: no pointer, entry or count update. All *_valid and flush outputs go to 0 on that edge; data outputs hold.
- Per entry, the buffer stores: busy, ready, pc, has_rd, rd, is_branch, pred_taken, value, taken, target.
- Allocate: when id_valid && !rob_full && !flush, the tail entry becomes busy with ready = 0 and tail increments modulo ROB_SIZE. Allocation while full is dropped silently; the decoder stalls on rob_full.
- Writeback: when alu_valid && busy[alu_rob_id], the entry stores value, taken and target, and ready = 1.
  - bcast_* is registered: it is asserted the edge after the writeback with the same id and value, for exactly one cycle.
  - A writeback to a non-busy entry is ignored and produces no broadcast.
- Commit: at most one entry per cycle, when busy[head] && ready[head].
  - If has_rd and rd != 0: rf_commit_valid = 1 with rd, value and id, registered for one cycle.
  - head increments and the entry's busy bit clears.
  - A branch commits no regfile write.
- Mispredict: a committing branch with taken != pred_taken sets flush = 1 for one cycle.
  - flush_pc = target if taken, otherwise pc + 4 (32-bit wrap).
  - The same edge clears all busy/ready bits and sets head = tail = count = 0.
- Count: +1 on allocate, -1 on commit; a simultaneous allocate and commit leaves count unchanged. On the full-and-commit cycle, the allocation is still refused because rob_full is evaluated before the edge.
- Flush cycle: when flush is high, allocate, writeback and broadcast are all suppressed. The first allocation after a flush receives id 0.
- Wrap-around: head and tail wrap 15 -> 0. Entries are never overwritten while busy.
- Latency: allocate -> visible on the next edge; writeback -> bcast at +1; ready -> commit at +1 edge (baseline).

Optional Feature:
- Macro: ROB_BYPASS_EN.
- When defined: if alu_valid && alu_rob_id == head && busy[head] && !ready[head], the head commits in the same cycle using the alu_* values (also bcast at +1). Writeback-to-commit latency drops from 2 edges to 1, and mispredict detection is likewise one edge earlier.
- When undefined: commit only from stored ready entries, as described in Behaviour.

Test Plan:
- Allocate 3 non-branch instructions (rd=1,2,3, pc 0x0,0x4,0x8), then write back id 0..2 with values 0xA,0xB,0xC in order -> bcast ids 0,1,2 with matching values one cycle after each writeback; rf_commit rd 1,2,3 with values 0xA,0xB,0xC in order; count returns to 0.
- Out-of-order writeback ids 2,1,0 -> bcast follows writeback order 2,1,0; commits still occur in order 0,1,2, all on the edges after id 0 becomes ready.
- Allocate 16 instructions -> rob_full = 1 and a 17th id_valid is dropped (tail stays at 0). Write back and commit id 0 -> rob_full drops the next cycle and the next allocation receives id 0.
- Branch at pc 0x100, pred_taken = 0, with alu_taken = 1 and target 0x200, followed by 2 younger entries -> at branch commit flush = 1 and flush_pc = 0x200. Younger entries are cleared and never commit; the next rob_new_id is 0.
- Branch pred_taken = 1, alu_taken = 0 at pc 0xFFFFFFFC -> flush_pc = 0x00000000 (wrap).
- rdy held low for 3 cycles while alu_valid is pulsed -> no state change and no pulses; the writeback is lost. Then assert rst mid-operation with 5 busy entries -> all outputs 0 and count 0 on the next edge.
